nbbpu_mem_arbiter: RTL and testbench
====================================

Name: nbbpu_mem_arbiter

Overview:
Shares one synchronous single-port data RAM between two requesters: the NBBPU data port (CPU) and a host/debug port (program loader, bench or UART bridge).
- Each requester uses a req/ready handshake.
- The arbiter grants round-robin, sequences one RAM access at a time through a small FSM, and returns registered read data with a one-cycle ready pulse.
- It sits between nbbpu and ram in the top level. The CPU stalls while cpu_req is high and cpu_ready is low.

Parameters:
- ADDR_WIDTH, 16, width of requester and RAM addresses.
- DATA_WIDTH, 16, word width.
- RAM_WORDS, 256, number of implemented RAM words; addresses >= RAM_WORDS are out of range.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with its fields until cpu_ready.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_address  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  registered read data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- host_req, host_write, host_address, host_wdata, host_rdata, host_ready: host copies of the above, with identical rules.
- host_lock  in  1  while 1, CPU requests are never granted.
- ram_write  out  1  RAM write enable.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data; valid one cycle after the address is presented.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (reset=0) takes effect immediately, asynchronously. It forces:
  - state=IDLE, owner=CPU, last_grant=HOST;
  - all ready outputs 0, all rdata outputs 0;
  - ram_write=0, ram_address=0, ram_wdata=0.
  - An access in flight is aborted: no ready pulse, and no RAM write after reset asserts.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE: evaluate eligible requesters.
  - Eligible means x_req=1 and x_ready=0 in this cycle. The CPU additionally needs host_lock=0.
  - If any requester is eligible: latch its write/address/wdata, set owner, set last_grant=owner, next state ACCESS.
  - Otherwise remain in IDLE.
- Tie-break: if both are eligible, grant the requester that is not last_grant. From reset, the CPU wins the first tie.
- ACCESS (one cycle):
  - ram_address and ram_wdata are driven from the latched request.
  - ram_write = latched write AND (latched address < RAM_WORDS).
  - Next state RESPOND.
- RESPOND (one cycle):
  - ram_write=0.
  - On the exit edge, assert owner's ready for exactly one cycle.
  - For an in-range read, owner's rdata <= ram_rdata. For an out-of-range read, owner's rdata <= 0. For a write, rdata is unchanged.
  - Arbitrate in the same cycle, with the owner excluded. If the other requester is eligible, go to ACCESS with it (back-to-back). Otherwise go to IDLE.
- Latency and throughput:
  - A request first sampled in IDLE in cycle C gets ready in cycle C+3.
  - Maximum throughput is one access per 2 cycles when both requesters are alternating.
- Handshake rules:
  - A requester holds req and its fields stable until it sees ready=1.
  - It may drop or re-raise req on the following edge.
  - req is ignored in any cycle where that requester's ready=1, so there are no duplicate grants.
- ram_address and ram_wdata hold their last values outside ACCESS. ram_write is 0 outside ACCESS.
- host_lock:
  - Sampled only at arbitration points; it never aborts a CPU access already granted.
  - While host_lock=1, a pending cpu_req simply waits.
- Out-of-range addresses (>= RAM_WORDS):
  - Writes are suppressed.
  - Reads return 0.
  - ready still pulses with normal latency.
- A requester dropping req mid-access is a protocol violation. The access still completes and ready still pulses.

Decomposition:
- Shared package nbbpu_pkg:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2);
  - owner encoding (OWNER_CPU=1'b0, OWNER_HOST=1'b1).
- One natural sub-module: nbbpu_rr_pick2. It is a combinational two-way round-robin picker taking eligible[1:0], last_grant and exclude_mask, and returning grant_valid and grant_id.

Test Plan:
- CPU read only: RAM[0x10]=0xBEEF, cpu_req high with address 0x10 -> ram_address=0x10 in cycle C+1, cpu_ready=1 and cpu_rdata=0xBEEF in C+3 only, busy high for C+1..C+2.
- Simultaneous first requests after reset: CPU reads 0x01, host writes 0xA5A5 to 0x02 -> CPU granted first. Host enters ACCESS the cycle after CPU's RESPOND; host_ready comes 2 cycles after cpu_ready; RAM[0x02]=0xA5A5.
- Both requesters hold req continuously for 6 accesses -> grants strictly alternate CPU,HOST,CPU,... with no duplicate ready pulses.
- host_lock=1 with both requesting -> only host grants while lock is high, cpu_ready stays 0. Lower lock -> CPU granted at the next arbitration point.
- CPU writes 0x1234 to address 0x0100 (RAM_WORDS=256) -> ram_write stays 0, cpu_ready pulses. A later read of 0x0100 returns 0x0000.
- Assert reset during ACCESS of a host write -> ram_write drops immediately, no host_ready, state=IDLE. After release, the first tie goes to the CPU.

Source files
------------

// File: rtl/nbbpu_pkg.sv
// Shared encodings for the NBBPU data-memory arbiter: FSM states and owner ids.
package nbbpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

endpackage : nbbpu_pkg

// File: rtl/nbbpu_rr_pick2.sv
// Two-way round-robin picker. Bit 0 of each mask is the CPU, bit 1 the host.
// On a tie the requester that was not granted last wins.
module nbbpu_rr_pick2
  import nbbpu_pkg::*;
(
  input  logic [1:0] eligible,
  input  owner_e     last_grant,
  input  logic [1:0] exclude_mask,
  output logic       grant_valid,
  output owner_e     grant_id
);

  logic [1:0] cand;

  assign cand = eligible & ~exclude_mask;

  // Choose one candidate, alternating on ties.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    grant_valid = |cand;
    grant_id    = OWNER_CPU;
    if (cand == 2'b11) begin
      grant_id = (last_grant == OWNER_CPU) ? OWNER_HOST : OWNER_CPU;
    end else if (cand[1]) begin
      grant_id = OWNER_HOST;
    end
  end

endmodule : nbbpu_rr_pick2

// File: rtl/nbbpu_mem_arbiter.sv
// Shares one synchronous single-port RAM between the NBBPU data port (CPU) and
// a host/debug port. One access at a time: IDLE -> ACCESS -> RESPOND, with a
// registered one-cycle ready pulse and registered read data per requester.
module nbbpu_mem_arbiter
  import nbbpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RAM_WORDS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  host_req,
  input  logic                  host_write,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ready,
  input  logic                  host_lock,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  // One extra bit so RAM_WORDS == 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(RAM_WORDS);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < RAM_LIMIT;
  endfunction

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_grant_q, last_grant_d;
  logic                  lat_write_q, lat_write_d;
  logic                  ram_write_q, ram_write_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic                  host_ready_q, host_ready_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  logic [1:0]            eligible;
  logic [1:0]            exclude_mask;
  logic                  grant_valid;
  owner_e                grant_id;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] read_data;

  // A requester whose ready is high this cycle is ignored, which prevents a
  // duplicate grant of a request the requester has not yet withdrawn.
  assign eligible[0] = cpu_req  & ~cpu_ready_q & ~host_lock;
  assign eligible[1] = host_req & ~host_ready_q;

  // Only RESPOND excludes the current owner so the other side gets the slot.
  assign exclude_mask = (state_q != RESPOND)    ? 2'b00 :
                        (owner_q == OWNER_HOST) ? 2'b10 : 2'b01;

  nbbpu_rr_pick2 u_pick (
    .eligible     (eligible),
    .last_grant   (last_grant_q),
    .exclude_mask (exclude_mask),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  assign sel_write   = (grant_id == OWNER_HOST) ? host_write   : cpu_write;
  assign sel_address = (grant_id == OWNER_HOST) ? host_address : cpu_address;
  assign sel_wdata   = (grant_id == OWNER_HOST) ? host_wdata   : cpu_wdata;

  // Out-of-range reads return zero instead of whatever the RAM aliases to.
  assign read_data = in_range(ram_address_q) ? ram_rdata : '0;

  // Next-state, grant and response logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    lat_write_d   = lat_write_q;
    ram_write_d   = 1'b0;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    cpu_ready_d   = 1'b0;
    host_ready_d  = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    host_rdata_d  = host_rdata_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ACCESS: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        state_d = IDLE;
        if (owner_q == OWNER_HOST) begin
          host_ready_d = 1'b1;
          if (!lat_write_q) host_rdata_d = read_data;
        end else begin
          cpu_ready_d = 1'b1;
          if (!lat_write_q) cpu_rdata_d = read_data;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Arbitration points are IDLE and RESPOND; ACCESS never starts a grant.
    if (grant_valid && (state_q != ACCESS)) begin
      state_d       = ACCESS;
      owner_d       = grant_id;
      last_grant_d  = grant_id;
      lat_write_d   = sel_write;
      ram_address_d = sel_address;
      ram_wdata_d   = sel_wdata;
      ram_write_d   = sel_write & in_range(sel_address);
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= OWNER_CPU;
      last_grant_q  <= OWNER_HOST;
      lat_write_q   <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      host_ready_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      lat_write_q   <= lat_write_d;
      ram_write_q   <= ram_write_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      cpu_ready_q   <= cpu_ready_d;
      host_ready_q  <= host_ready_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign ram_write   = ram_write_q;
  assign ram_address = ram_address_q;
  assign ram_wdata   = ram_wdata_q;
  assign cpu_ready   = cpu_ready_q;
  assign host_ready  = host_ready_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign busy        = (state_q != IDLE);

endmodule : nbbpu_mem_arbiter

// File: tb/tb_nbbpu_mem_arbiter.sv
// Directed bench for nbbpu_mem_arbiter with a 256-word synchronous RAM model
// that aliases on the low address byte.
module tb_nbbpu_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_address = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        host_req = 1'b0, host_write = 1'b0;
  logic [15:0] host_address = '0, host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_ready;
  logic        host_lock = 1'b0;
  logic        ram_write;
  logic [15:0] ram_address, ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  nbbpu_mem_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .host_req     (host_req),
    .host_write   (host_write),
    .host_address (host_address),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .host_ready   (host_ready),
    .host_lock    (host_lock),
    .ram_write    (ram_write),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // RAM model: preset contents plus a written-word overlay.
  logic [15:0] wr_mem [0:255];
  bit          wr_vld [0:255];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h01:   return 16'h1111;
      8'h02:   return 16'h2222;
      8'h03:   return 16'h3333;
      8'h10:   return 16'hBEEF;
      default: return {8'hC0, a};
    endcase
  endfunction

  function automatic logic [15:0] mem_val(input logic [7:0] a);
    return wr_vld[a] ? wr_mem[a] : init_val(a);
  endfunction

  always @(posedge clock) begin
    if (ram_write) begin
      wr_mem[ram_address[7:0]] <= ram_wdata;
      wr_vld[ram_address[7:0]] <= 1'b1;
    end
    ram_rdata <= mem_val(ram_address[7:0]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_ready", {cpu_ready, host_ready}, 0);
    check("rst_rdata", {cpu_rdata, host_rdata}, 0);
    check("rst_ram", {ram_write, ram_address, ram_wdata}, 0);
    tick();
    reset = 1'b1;

    // CPU read only, cycle C = this cycle
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
    check("t1_busy_c", busy, 0);
    tick();
    check("t1_addr_c1", ram_address, 16'h0010);
    check("t1_busy_c1", busy, 1);
    check("t1_rdy_c1", cpu_ready, 0);
    tick();
    check("t1_busy_c2", busy, 1);
    check("t1_wr_c2", ram_write, 0);
    check("t1_rdy_c2", cpu_ready, 0);
    tick();
    check("t1_rdy_c3", cpu_ready, 1);
    check("t1_rdata_c3", cpu_rdata, 16'hBEEF);
    check("t1_busy_c3", busy, 0);
    tick();
    cpu_req = 1'b0;
    check("t1_rdy_c4", cpu_ready, 0);
    check("t1_nodup_c4", busy, 0);

    // Simultaneous first requests after reset
    do_reset();
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0001;
    host_req = 1'b1; host_write = 1'b1; host_address = 16'h0002; host_wdata = 16'hA5A5;
    tick();
    check("t2_addr_cpu", ram_address, 16'h0001);
    check("t2_wr_cpu", ram_write, 0);
    tick();
    check("t2_busy", busy, 1);
    tick();
    check("t2_cpu_rdy", cpu_ready, 1);
    check("t2_cpu_rdata", cpu_rdata, 16'h1111);
    check("t2_host_rdy_early", host_ready, 0);
    check("t2_host_access", {ram_write, ram_address, ram_wdata}, {1'b1, 16'h0002, 16'hA5A5});
    tick();
    cpu_req = 1'b0;
    check("t2_cpu_rdy_off", cpu_ready, 0);
    check("t2_wr_off", ram_write, 0);
    check("t2_host_rdy_c4", host_ready, 0);
    tick();
    check("t2_host_rdy", host_ready, 1);
    check("t2_host_rdata", host_rdata, 16'h0000);
    check("t2_ram2", mem_val(8'h02), 16'hA5A5);
    tick();
    host_req = 1'b0;
    check("t2_host_rdy_off", host_ready, 0);
    check("t2_idle", busy, 0);

    // Both hold req: grants alternate CPU,HOST,... (cycle D = k 0)
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
    host_req = 1'b1; host_write = 1'b0; host_address = 16'h0003;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 12) cpu_req = 1'b0;
      if (k == 14) host_req = 1'b0;
      check($sformatf("t3_cpu_rdy_k%0d", k), cpu_ready, (k == 3 || k == 7 || k == 11));
      check($sformatf("t3_host_rdy_k%0d", k), host_ready, (k == 5 || k == 9 || k == 13));
      if (k == 11) check("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
      if (k == 13) check("t3_host_rdata", host_rdata, 16'h3333);
    end

    // host_lock: only host grants until lock drops at k 8 (cycle E = k 0)
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
    host_req = 1'b1; host_write = 1'b0; host_address = 16'h0001;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 8) host_lock = 1'b0;
      if (k == 12) cpu_req = 1'b0;
      if (k == 14) host_req = 1'b0;
      check($sformatf("t4_cpu_rdy_k%0d", k), cpu_ready, (k == 11));
      check($sformatf("t4_host_rdy_k%0d", k), host_ready, (k == 3 || k == 7 || k == 13));
    end
    check("t4_host_rdata", host_rdata, 16'h1111);

    // Out-of-range write is suppressed, out-of-range read returns 0
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_address = 16'h0100; cpu_wdata = 16'h1234;
    tick();
    check("t5_wr_sup", ram_write, 0);
    check("t5_addr", ram_address, 16'h0100);
    tick();
    tick();
    check("t5_wr_rdy", cpu_ready, 1);
    check("t5_wr_rdata_keep", cpu_rdata, 16'hBEEF);
    tick();
    cpu_req = 1'b0;
    check("t5_wr_rdy_off", cpu_ready, 0);
    check("t5_ram0", mem_val(8'h00), 16'hC000);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0100;
    tick();
    tick();
    tick();
    check("t5_rd_rdy", cpu_ready, 1);
    check("t5_rd_zero", cpu_rdata, 16'h0000);
    tick();
    cpu_req = 1'b0;

    // Reset during ACCESS of a host write
    host_req = 1'b1; host_write = 1'b1; host_address = 16'h0003; host_wdata = 16'h5A5A;
    tick();
    check("t6_access", ram_write, 1);
    #1 reset = 1'b0;
    #1;
    check("t6_wr_drop", ram_write, 0);
    check("t6_idle", busy, 0);
    check("t6_addr0", ram_address, 16'h0000);
    tick();
    check("t6_no_write", mem_val(8'h03), 16'h3333);
    check("t6_no_rdy", host_ready, 0);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
    reset = 1'b1;
    tick();
    check("t6_tie_cpu", ram_address, 16'h0010);
    tick();
    tick();
    check("t6_cpu_rdy", cpu_ready, 1);
    check("t6_host_rdy0", host_ready, 0);
    check("t6_host_access", {ram_write, ram_address}, {1'b1, 16'h0003});
    tick();
    cpu_req = 1'b0;
    tick();
    check("t6_host_rdy", host_ready, 1);
    check("t6_ram3", mem_val(8'h03), 16'h5A5A);
    host_req = 1'b0;
    tick();
    tick();
    check("t6_end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nbbpu_mem_arbiter
